// File: rtl/vx_socket_mem_arb.sv
// Round-robin arbiter sharing one L2 request port among socket requesters.
// Tags the request with the requester index, routes responses back, throttles reads.
module vx_socket_mem_arb #(
  parameter  int NUM_REQS    = 4,
  parameter  int ADDR_WIDTH  = 26,
  parameter  int DATA_SIZE   = 64,
  parameter  int TAG_WIDTH   = 8,
  parameter  int MAX_PENDING = 8,
  localparam int SEL_BITS    = $clog2(NUM_REQS),
  localparam int MEM_TAG_W   = TAG_WIDTH + SEL_BITS,
  localparam int DATA_W      = DATA_SIZE * 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  input  logic [NUM_REQS-1:0]             req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQS*DATA_W-1:0]      req_data,
  input  logic [NUM_REQS*DATA_SIZE-1:0]   req_byteen,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]   req_tag,
  output logic [NUM_REQS-1:0]             req_ready,
  output logic [NUM_REQS-1:0]             rsp_valid,
  output logic [DATA_W-1:0]               rsp_data,
  output logic [TAG_WIDTH-1:0]            rsp_tag,
  input  logic [NUM_REQS-1:0]             rsp_ready,
  output logic                            mem_req_valid,
  output logic                            mem_req_rw,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr,
  output logic [DATA_W-1:0]               mem_req_data,
  output logic [DATA_SIZE-1:0]            mem_req_byteen,
  output logic [MEM_TAG_W-1:0]            mem_req_tag,
  input  logic                            mem_req_ready,
  input  logic                            mem_rsp_valid,
  input  logic [DATA_W-1:0]               mem_rsp_data,
  input  logic [MEM_TAG_W-1:0]            mem_rsp_tag,
  output logic                            mem_rsp_ready,
  output logic                            busy
);
  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [SEL_BITS-1:0] rr_ptr;
  logic [CNT_W-1:0]    pend      [NUM_REQS];
  logic [CNT_W-1:0]    pend_next [NUM_REQS];
  logic [NUM_REQS-1:0] eligible;
  logic [NUM_REQS-1:0] rd_inc;
  logic [NUM_REQS-1:0] rsp_dec;
  logic [SEL_BITS-1:0] winner;
  logic [SEL_BITS-1:0] rsp_idx;
  logic                found;
  logic                can_load;
  logic                grant;
  logic                valid_next;
  logic                any_pend_next;
  int                  cand;

  // Writes never count toward the outstanding-read limit.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQS; i++)
      eligible[i] = req_valid[i] && !(!req_rw[i] && pend[i] == CNT_W'(MAX_PENDING));
  end

  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQS) cand = cand - NUM_REQS;
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = SEL_BITS'(cand);
      end
    end
  end

  assign can_load   = !mem_req_valid || mem_req_ready;
  assign grant      = reset && can_load && found;
  assign valid_next = grant ? 1'b1 : (mem_req_ready ? 1'b0 : mem_req_valid);

  always_comb begin
    req_ready = '0;
    rd_inc    = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant && winner == SEL_BITS'(i)) begin
        req_ready[i] = 1'b1;
        rd_inc[i]    = !req_rw[i];
      end
    end
  end

  assign rsp_idx  = mem_rsp_tag[SEL_BITS-1:0];
  assign rsp_tag  = mem_rsp_tag[MEM_TAG_W-1:SEL_BITS];
  assign rsp_data = mem_rsp_data;

  // Indices with no matching requester keep ready high so stray responses drain.
  always_comb begin
    rsp_valid     = '0;
    rsp_dec       = '0;
    mem_rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (rsp_idx == SEL_BITS'(i)) begin
        rsp_valid[i]  = mem_rsp_valid;
        mem_rsp_ready = rsp_ready[i];
        rsp_dec[i]    = mem_rsp_valid && rsp_ready[i];
      end
    end
  end

  always_comb begin
    any_pend_next = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      pend_next[i] = pend[i];
      if (rd_inc[i] && !rsp_dec[i])
        pend_next[i] = pend[i] + CNT_W'(1);
      else if (rsp_dec[i] && !rd_inc[i] && pend[i] != '0)
        pend_next[i] = pend[i] - CNT_W'(1);
      any_pend_next = any_pend_next || (pend_next[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req_valid  <= 1'b0;
      mem_req_rw     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_data   <= '0;
      mem_req_byteen <= '0;
      mem_req_tag    <= '0;
      rr_ptr         <= '0;
      busy           <= 1'b0;
      for (int i = 0; i < NUM_REQS; i++) pend[i] <= '0;
    end else begin
      mem_req_valid <= valid_next;
      if (grant) begin
        mem_req_rw     <= req_rw[winner];
        mem_req_addr   <= req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_req_data   <= req_data[int'(winner)*DATA_W +: DATA_W];
        mem_req_byteen <= req_byteen[int'(winner)*DATA_SIZE +: DATA_SIZE];
        mem_req_tag    <= {req_tag[int'(winner)*TAG_WIDTH +: TAG_WIDTH], winner};
        rr_ptr         <= (winner == SEL_BITS'(NUM_REQS - 1)) ? '0 : winner + 1'b1;
      end
      for (int i = 0; i < NUM_REQS; i++) pend[i] <= pend_next[i];
      busy <= valid_next || any_pend_next;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQS; i++)
        if (rsp_dec[i] && !rd_inc[i])
          assert (pend[i] != '0) else $error("response to requester %0d with no pending read", i);
      if (mem_rsp_valid)
        assert (int'(rsp_idx) < NUM_REQS) else $error("response index %0d out of range", rsp_idx);
    end
  end
`endif

endmodule

// File: doc/vx_socket_mem_arb.md
Name: VX_socket_mem_arb

Overview:
- Round-robin arbiter sharing one L2 core-side request port among NUM_REQS socket memory requesters.
- Appends the requester index to the outgoing tag and routes responses back by that index.
- Tracks outstanding reads per requester, throttles any requester at MAX_PENDING, and reports busy to the cluster.

Parameters:
NUM_REQS, 4, number of requesters (≥2); SEL_BITS = clog2(NUM_REQS)
ADDR_WIDTH, 26, line address width
DATA_SIZE, 64, bytes per request/response word
TAG_WIDTH, 8, requester-side tag width; memory tag = TAG_WIDTH+SEL_BITS
MAX_PENDING, 8, max outstanding reads per requester (≥1); counter width clog2(MAX_PENDING+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (asserted when 0)
req_valid  in  NUM_REQS  per-requester request valid
req_rw  in  NUM_REQS  1=write, 0=read
req_addr  in  NUM_REQS*ADDR_WIDTH  packed addresses
req_data  in  NUM_REQS*DATA_SIZE*8  packed write data
req_byteen  in  NUM_REQS*DATA_SIZE  packed byte enables
req_tag  in  NUM_REQS*TAG_WIDTH  packed tags
req_ready  out  NUM_REQS  request accepted when valid&ready
rsp_valid  out  NUM_REQS  per-requester response valid
rsp_data  out  DATA_SIZE*8  response data, shared by all requesters
rsp_tag  out  TAG_WIDTH  original requester tag
rsp_ready  in  NUM_REQS  per-requester response ready
mem_req_valid, mem_req_rw  out  1 each  registered request to L2
mem_req_addr/data/byteen  out  ADDR_WIDTH / DATA_SIZE*8 / DATA_SIZE  registered payload
mem_req_tag  out  TAG_WIDTH+SEL_BITS  {req_tag, index}, index in LSBs
mem_req_ready  in  1  L2 accepts
mem_rsp_valid  in  1  L2 response valid
mem_rsp_data  in  DATA_SIZE*8  response data
mem_rsp_tag  in  TAG_WIDTH+SEL_BITS  response tag
mem_rsp_ready  out  1  response accepted
busy  out  1  requests pending

Behaviour:
- Reset (reset==0 at posedge):
  - mem_req_valid=0, rr_ptr=0, all pending counters=0, busy=0.
  - req_ready=0 while reset is held; resets mid-transfer and discards the output slot.
- Eligibility: eligible[i] = req_valid[i] && !(req_rw[i]==0 && pend[i]==MAX_PENDING). A write is never throttled.
- Arbitration:
  - Fixed round-robin starting at rr_ptr: the first eligible index at or after rr_ptr (mod NUM_REQS) wins.
  - On grant, rr_ptr <= winner+1 (wraps NUM_REQS-1 -> 0). rr_ptr is unchanged when there is no grant.
- Output stage: single registered slot. can_load = !mem_req_valid || mem_req_ready.
  - req_ready[i] = can_load && (i==winner) && eligible[i]; at most one requester is ready per cycle.
  - On grant, the slot loads the winner's payload with tag {req_tag[w], w[SEL_BITS-1:0]} and mem_req_valid <= 1.
  - Slot is cleared when mem_req_ready and no grant.
  - Latency: 1 cycle from req handshake to mem_req_valid.
  - Full throughput: 1 request/cycle while mem_req_ready=1.
- Payload stability: the payload is held while mem_req_valid && !mem_req_ready.
- Pending counters:
  - pend[w]++ on a read grant; pend[j]-- on a response handshake with index j.
  - Simultaneous increment and decrement on the same index leaves the counter unchanged.
  - Decrement at 0: saturate at 0 and fire a simulation assertion.
- Response routing (combinational, 0 latency):
  - idx = mem_rsp_tag[SEL_BITS-1:0].
  - rsp_valid[i] = mem_rsp_valid && idx==i; rsp_tag = mem_rsp_tag[TAG+SEL-1:SEL]; rsp_data = mem_rsp_data.
  - mem_rsp_ready = rsp_ready[idx].
  - idx ≥ NUM_REQS (non-power-of-2 NUM_REQS): mem_rsp_ready=1, response dropped, assertion fires.
- busy (registered): busy <= mem_req_valid_next || (any pend_next != 0). Goes low the cycle after the last response is consumed and the slot is empty.

Test Plan:
- Reset hold: reset=0 for 3 cycles with all req_valid=1 -> req_ready=0, mem_req_valid=0, busy=0; after release, the first grant goes to index 0.
- Fairness: NUM_REQS=4, all requesters continuously valid reads, mem_req_ready=1 -> grant order 0,1,2,3,0,... and mem_req_tag LSBs match that order, one request per cycle.
- Backpressure: mem_req_ready=0 for 5 cycles with requester 2 valid, tag 0x5A -> mem_req_valid=1 and mem_req_tag=0x5A<<2|2 held stable, req_ready=0; on ready, the request is consumed and the next grant loads in the same cycle.
- Throttle: requester 1 issues 8 reads with no responses (MAX_PENDING=8) -> 9th read not granted while requester 1 writes and requester 0 still proceed; one response to index 1 -> next cycle the read is granted.
- Response routing: mem_rsp_tag=(0x33<<2)|3 with rsp_ready[3]=0 -> rsp_valid=4'b1000, mem_rsp_ready=0; raising rsp_ready[3] completes it and pend[3] decrements.
- Simultaneous grant and response on requester 0 with pend[0]=4 -> pend[0] stays 4; draining all responses -> busy falls 1 cycle after the last handshake.
